// File: rtl/adder_tree_accum.sv
// Consumes a fixed-latency adder tree: times its results with a valid pipe, sums COUNT of them
// per group, and queues group sums in a 2-entry FIFO. Define ADDER_TREE_ACCUM_SAT_EN to saturate.
module adder_tree_accum #(
    parameter int W     = 8,
    parameter int ACC_W = 16,
    parameter int LAT   = 3,
    parameter int COUNT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [W-1:0]               tree_sum,
    output logic [ACC_W-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(COUNT+1)-1:0] grp_count,
    output logic                       overflow
);
    localparam int CW = $clog2(COUNT + 1);

    logic [LAT-1:0]   vpipe_q, vpipe_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [ACC_W-1:0] last_q, last_d;
    logic             ovf_q, ovf_d;
    logic             sample, push, pop, push_ok;

`ifdef ADDER_TREE_ACCUM_SAT_EN
    logic [ACC_W:0] sum_wide;
    // Operands are unsigned, so a carry out means the true sum exceeds the maximum.
    assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(tree_sum);
    assign acc_next = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
`else
    assign acc_next = acc_q + ACC_W'(tree_sum);
`endif

    assign sample = vpipe_q[LAT-1];

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        vpipe_d    = vpipe_q;
        vpipe_d[0] = in_valid;
        for (int i = 1; i < LAT; i++) vpipe_d[i] = vpipe_q[i-1];

        push  = 1'b0;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (sample) begin
            if (cnt_q == CW'(COUNT - 1)) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A pop in the same cycle frees the slot a full-queue push needs.
        pop      = (occ_q != 2'd0) && out_ready;
        push_ok  = push && ((occ_q != 2'd2) || pop);
        occ_d    = occ_q + {1'b0, push_ok} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop;
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
        ovf_d    = ovf_q | (push & ~push_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            vpipe_q  <= vpipe_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: queue storage is not reset; occupancy gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= acc_next;
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign grp_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Self-checking bench for adder_tree_accum: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_adder_tree_accum;
    localparam int W     = 8;
    localparam int ACC_W = 16;
    localparam int LAT   = 3;
    localparam int COUNT = 4;
    localparam int CW    = $clog2(COUNT + 1);
    localparam longint MAXV = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, out_ready, out_valid, overflow;
    logic [W-1:0]     tree_sum;
    logic [ACC_W-1:0] out_data;
    logic [CW-1:0]    grp_count;

    logic       b_in_valid, b_out_ready, b_out_valid, b_overflow;
    logic [7:0] b_tree_sum, b_out_data;
    logic [1:0] b_grp_count;

    always #5 clk = ~clk;

    adder_tree_accum #(.W(W), .ACC_W(ACC_W), .LAT(LAT), .COUNT(COUNT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .tree_sum(tree_sum),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grp_count(grp_count), .overflow(overflow)
    );

    adder_tree_accum #(.W(8), .ACC_W(8), .LAT(1), .COUNT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .tree_sum(b_tree_sum),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .grp_count(b_grp_count), .overflow(b_overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: launch cycles are booked LAT ahead; samples gather into a group list,
    // finished groups go into a bounded expected-output queue.
    int          cyc = 0;
    bit          launched[int];
    int unsigned tsv[int];
    int unsigned grp[$];
    int unsigned exq[$];
    int unsigned m_last;
    bit          m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        launched.delete();
        grp.delete();
        exq.delete();
        m_last = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step();
        bit     pop;
        longint s;
        pop = (exq.size() > 0) && out_ready;
        if (pop) m_last = exq.pop_front();
        if (launched.exists(cyc)) begin
            launched.delete(cyc);
            grp.push_back(tree_sum);
            if (grp.size() == COUNT) begin
                s = 0;
                foreach (grp[i]) s += grp[i];
`ifdef ADDER_TREE_ACCUM_SAT_EN
                if (s > MAXV) s = MAXV;
`else
                s = s % (MAXV + 1);
`endif
                if (exq.size() < 2) exq.push_back(int'(s));
                else m_ovf = 1;
                grp.delete();
            end
        end
        if (in_valid) launched[cyc + LAT] = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic check_model();
        check("out_valid", out_valid, exq.size() > 0);
        check("out_data", out_data, (exq.size() > 0) ? exq[0] : m_last);
        check("grp_count", grp_count, grp.size());
        check("overflow", overflow, m_ovf);
    endtask

    // One cycle: inputs change on the falling edge, outputs checked just after.
    task automatic step(input bit iv, input int unsigned v, input bit rdy);
        @(negedge clk);
        in_valid  = iv;
        out_ready = rdy;
        if (iv) tsv[cyc + LAT] = v;
        tree_sum = tsv.exists(cyc) ? W'(tsv[cyc]) : W'($urandom);
        #1 check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          iv;
        int unsigned ts;
        bit          rdy;
        bit          e_valid;
        int unsigned e_data;
        int unsigned e_gc;
    } vec_t;

    vec_t        tbl[9];
    int          pops;
    int          s0;
    int unsigned exp_b;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 1, 1, 0, 0, 0};
        tbl[1] = '{1, 2, 1, 0, 0, 0};
        tbl[2] = '{1, 3, 1, 0, 0, 0};
        tbl[3] = '{1, 4, 1, 0, 0, 0};
        tbl[4] = '{0, 0, 1, 0, 0, 1};
        tbl[5] = '{0, 0, 1, 0, 0, 2};
        tbl[6] = '{0, 0, 1, 0, 0, 3};
        tbl[7] = '{0, 0, 1, 1, 10, 0};
        tbl[8] = '{0, 0, 1, 0, 10, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tree_sum = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_tree_sum = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst overflow", overflow, 0);
        check("rst grp_count", grp_count, 0);
        check("rst b out_valid", b_out_valid, 0);

        // Single group 1+2+3+4 through the LAT=3 pipe.
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].iv, tbl[k].ts, tbl[k].rdy);
            check($sformatf("tbl%0d out_valid", k), out_valid, tbl[k].e_valid);
            check($sformatf("tbl%0d out_data", k), out_data, tbl[k].e_data);
            check($sformatf("tbl%0d grp_count", k), grp_count, tbl[k].e_gc);
        end

        // Narrow instance: 200 + 100 in an 8-bit accumulator.
`ifdef ADDER_TREE_ACCUM_SAT_EN
        exp_b = 255;
`else
        exp_b = 44;
`endif
        @(negedge clk); b_in_valid = 1'b1;
        @(negedge clk); b_in_valid = 1'b1; b_tree_sum = 8'd200;
        @(negedge clk); b_in_valid = 1'b0; b_tree_sum = 8'd100;
        #1 check("width grp_count mid", b_grp_count, 1);
        @(negedge clk); b_tree_sum = 8'd0;
        #1;
        check("width out_valid", b_out_valid, 1);
        check("width out_data", b_out_data, exp_b);
        check("width grp_count", b_grp_count, 0);

        // Backpressure: three groups of 5 with the consumer stalled.
        repeat (12) step(1, 5, 0);
        repeat (LAT + 2) step(0, 0, 0);
        check("ovf set", overflow, 1);
        check("ovf head valid", out_valid, 1);
        check("ovf head data", out_data, 20);
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1);
            if (out_valid) begin
                pops++;
                check("drain data", out_data, 20);
            end
        end
        check("drain pops", pops, 2);
        check("drain empty", out_valid, 0);
        check("ovf sticky", overflow, 1);

        // Queue full while a third group completes with a pop in the same cycle.
        do_reset();
        s0 = cyc + 1;
        for (int j = 0; j < 4; j++) step(1, j + 1, 0);
        for (int j = 0; j < 4; j++) step(1, j + 5, 0);
        for (int j = 0; j < 4; j++) step(1, 10 * (j + 1), 0);
        for (int j = 0; j < LAT + 2; j++) step(0, 0, (cyc + 1) == (s0 + 11 + LAT));
        check("pp no overflow", overflow, 0);
        check("pp head0", out_data, 26);
        step(0, 0, 1);
        step(0, 0, 1);
        check("pp head1", out_data, 100);
        step(0, 0, 0);
        check("pp empty", out_valid, 0);
        check("pp last", out_data, 100);

        // Asynchronous reset after two of four samples.
        step(1, 3, 1);
        step(1, 3, 1);
        repeat (LAT + 1) step(0, 0, 1);
        check("mid grp_count", grp_count, 2);
        #1 rst_n = 1'b0;
        #1;
        check("async out_valid", out_valid, 0);
        check("async out_data", out_data, 0);
        check("async grp_count", grp_count, 0);
        check("async overflow", overflow, 0);
        @(negedge clk); in_valid = 1'b1;
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        repeat (4) step(1, 3, 0);
        repeat (LAT + 3) step(0, 0, 0);
        check("post-reset valid", out_valid, 1);
        check("post-reset data", out_data, 12);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 255), $urandom_range(0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_tree_accum.md
Name: adder_tree_accum

Overview:
- Downstream consumer of the registered adder tree.
- Tracks tree latency with its own valid pipe, samples each tree result when it emerges, and accumulates COUNT results into one group sum.
- Completed group sums are delivered through a 2-entry output queue with a valid/ready handshake.
- The tree cannot be stalled, so the block absorbs backpressure itself and flags loss.

Parameters:
- W, 8, width of tree_sum.
- ACC_W, 16, accumulator and output width; ACC_W >= W.
- LAT, 3, clock cycles from operand launch into the tree to tree_sum valid; LAT >= 1.
- COUNT, 4, tree results per group; COUNT >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands launched into the tree this cycle.
- tree_sum  input  W  tree output; meaningful LAT cycles after the matching in_valid.
- out_data  output  ACC_W  head-of-queue group sum.
- out_valid  output  1  queue non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- grp_count  output  $clog2(COUNT+1)  results accumulated in the current partial group.
- overflow  output  1  sticky: a completed group was dropped because the queue was full.

Behaviour:
- Reset (rst_n low, asynchronous): valid pipe, acc, grp_count, queue pointers and occupancy cleared; out_valid=0, out_data=0, overflow=0. Release is synchronous to clk.
- Valid pipe: LAT-deep shift register; stage 0 loads in_valid each cycle. Tail=1 defines a "sample" cycle: tree_sum is taken at that clock edge.
- Back-to-back in_valid gives one sample per cycle. No gaps or reordering.
- Accumulate: on a sample, next = acc + zero-extend(tree_sum) at ACC_W bits.
  - If grp_count < COUNT-1: acc <= next, grp_count++.
  - If grp_count == COUNT-1: the group completes. next is pushed to the queue; acc <= 0, grp_count <= 0.
  - The completing sample is included in the pushed value. acc and grp_count reset regardless of whether the push succeeds.
- COUNT=1: every sample pushes zero-extend(tree_sum); grp_count stays 0.
- Queue: 2 entries, FIFO order.
  - Pop when out_valid && out_ready.
  - Push on group completion.
  - Push and pop in the same cycle with queue full: both succeed (pop frees the slot first); no drop.
  - Push with queue full and no pop: value discarded, overflow <= 1. overflow stays 1 until reset.
  - Push into an empty queue: out_valid=1 the next cycle. Minimum latency from the last sample edge to out_valid is 1 cycle.
- out_data equals the head entry while out_valid=1; it holds stable until popped. When the queue is empty, out_data holds its last value (0 after reset).
- in_valid pulses that arrive while reset is asserted are lost; the pipe restarts empty.
- Reset mid-group discards the partial group.
- Wrap vs. saturate: see Optional Feature.

Optional Feature:
- Macro: ADDER_TREE_ACCUM_SAT_EN.
- Defined: the accumulator add saturates at 2^ACC_W-1. Once saturated, acc holds that value for the rest of the group, and the pushed group sum is 2^ACC_W-1.
- Not defined: modulo-2^ACC_W wrap, no indication.
- Reset and grouping behaviour are identical in both builds.

Test Plan:
- Reset defaults: hold rst_n=0 for 3 cycles, release -> out_valid=0, out_data=0, overflow=0, grp_count=0.
- Group sum and latency: LAT=3, COUNT=4. Drive in_valid at cycles 0-3 with tree_sum=1,2,3,4 aligned at cycles 3-6, out_ready=1 -> out_valid=1 at cycle 7 with out_data=10 for one cycle. grp_count steps 1,2,3,0.
- Backpressure and overflow: out_ready=0, three complete groups of tree_sum=5 -> first two groups queued as 20,20; third dropped, overflow=1. Then out_ready=1 -> exactly two pops of 20, out_valid=0 after; overflow stays 1.
- Simultaneous push/pop at full: queue full, out_ready=1 in the cycle a group completes -> no drop, overflow=0, FIFO order preserved.
- Width boundary: W=8, ACC_W=8, COUNT=2, samples 200 and 100 -> pushed value 255 with ADDER_TREE_ACCUM_SAT_EN defined, 44 without.
- Async reset mid-group: after 2 of 4 samples, pulse rst_n low between clock edges -> outputs clear immediately. The next 4 samples of 3 produce out_data=12.
